// File: rtl/ram_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_read_arbiter_if
// Brief    : Signal bundle joining the ping-pong RAM read side, two buffer
//            consumers and the read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_read_arbiter_if #(
  parameter int DATA_W = 36
);
  logic [DATA_W-1:0] ram_read_data_i;
  logic              ram_read_valid_i;
  logic              ram_read_ready_o;
  logic              ram_buffer_ready_i;
  logic [1:0]        req_i;
  logic [DATA_W-1:0] c0_data_o;
  logic [DATA_W-1:0] c1_data_o;
  logic              c0_valid_o;
  logic              c1_valid_o;
  logic              c0_ready_i;
  logic              c1_ready_i;
  logic              c0_buffer_ready_o;
  logic              c1_buffer_ready_o;
  logic              c0_last_o;
  logic              c1_last_o;
  logic [1:0]        grant_o;
  logic              busy_o;
  logic [15:0]       drop_count_o;
  logic              overrun_o;

  // Environment side: RAM, consumers and their requests.
  modport master (
    output ram_read_data_i, ram_read_valid_i, ram_buffer_ready_i, req_i,
           c0_ready_i, c1_ready_i,
    input  ram_read_ready_o, c0_data_o, c1_data_o, c0_valid_o, c1_valid_o,
           c0_buffer_ready_o, c1_buffer_ready_o, c0_last_o, c1_last_o,
           grant_o, busy_o, drop_count_o, overrun_o
  );

  // Arbiter side.
  modport slave (
    input  ram_read_data_i, ram_read_valid_i, ram_buffer_ready_i, req_i,
           c0_ready_i, c1_ready_i,
    output ram_read_ready_o, c0_data_o, c1_data_o, c0_valid_o, c1_valid_o,
           c0_buffer_ready_o, c1_buffer_ready_o, c0_last_o, c1_last_o,
           grant_o, busy_o, drop_count_o, overrun_o
  );
endinterface
`default_nettype wire

// File: rtl/ram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_read_arbiter
// Brief    : Hands whole ping-pong RAM buffers to one of two consumers,
//            round-robin, draining unclaimed buffers so swapping never stalls.
// Revision : 1.0 - initial release
// ============================================================================
module ram_read_arbiter #(
  parameter int DATA_W    = 36,
  parameter int BUF_DEPTH = 256,
  parameter int CNT_W     = $clog2(BUF_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ram_read_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [15:0]      c_drop_max  = 16'hFFFF;
  localparam logic [15:0]      c_drop_one  = 16'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_pending;
  logic              r_last_served;
  logic              r_grant;
  logic [1:0]        r_buf_rdy;
  logic [15:0]       r_drop_cnt;
  logic              r_overrun;

  logic              w_avail;
  logic              w_win;
  logic              w_grant_now;
  logic              w_drain_now;
  logic              w_ram_ready;
  logic              w_beat;
  logic              w_at_last;
  logic              w_last_beat;
  logic              w_c0_valid;
  logic              w_c1_valid;
  logic [DATA_W-1:0] w_data;

  always_comb begin
    w_avail      = bus.ram_buffer_ready_i | r_pending;
    // A sole requester wins outright; a tie goes to the port not served last.
    w_win        = (bus.req_i == 2'b11) ? ~r_last_served : bus.req_i[1];
    w_grant_now  = (r_state == S_IDLE) & w_avail & (bus.req_i != 2'b00);
    w_drain_now  = (r_state == S_IDLE) & w_avail & (bus.req_i == 2'b00);

    w_ram_ready = 1'b0;
    case (r_state)
      S_GRANT: w_ram_ready = r_grant ? bus.c1_ready_i : bus.c0_ready_i;
      S_DRAIN: w_ram_ready = 1'b1;
      default: w_ram_ready = 1'b0;
    endcase

    w_beat      = bus.ram_read_valid_i & w_ram_ready;
    w_at_last   = (r_beat_cnt == c_last_beat);
    w_last_beat = w_beat & w_at_last;

    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_now)      w_next_state = S_GRANT;
        else if (w_drain_now) w_next_state = S_DRAIN;
      end
      S_GRANT: begin
        if (w_last_beat)               w_next_state = S_IDLE;
        else if (!bus.req_i[r_grant])  w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_beat) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_beat_cnt    <= '0;
      r_pending     <= 1'b0;
      r_last_served <= 1'b1;
      r_grant       <= 1'b0;
      r_buf_rdy     <= 2'b00;
      r_drop_cnt    <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // Withdrawn bursts keep counting so the drain ends on the buffer boundary.
      if (w_last_beat)
        r_beat_cnt <= '0;
      else if (w_beat)
        r_beat_cnt <= r_beat_cnt + c_cnt_one;

      r_buf_rdy <= 2'b00;
      if (w_grant_now) begin
        r_grant   <= w_win;
        r_buf_rdy <= {w_win, ~w_win};
      end

      if (w_drain_now && (r_drop_cnt != c_drop_max))
        r_drop_cnt <= r_drop_cnt + c_drop_one;

      if ((r_state == S_GRANT) && w_last_beat)
        r_last_served <= r_grant;

      // Leaving IDLE consumes one event; a pulse landing at that moment is kept.
      if (w_grant_now || w_drain_now) begin
        r_pending <= r_pending & bus.ram_buffer_ready_i;
      end else if (bus.ram_buffer_ready_i) begin
        r_pending <= 1'b1;
        if (r_pending)
          r_overrun <= 1'b1;
      end
    end
  end

  assign w_data     = bus.ram_read_data_i;
  assign w_c0_valid = (r_state == S_GRANT) & ~r_grant & bus.ram_read_valid_i;
  assign w_c1_valid = (r_state == S_GRANT) &  r_grant & bus.ram_read_valid_i;

  assign bus.ram_read_ready_o  = w_ram_ready;
  assign bus.c0_data_o         = w_data;
  assign bus.c1_data_o         = w_data;
  assign bus.c0_valid_o        = w_c0_valid;
  assign bus.c1_valid_o        = w_c1_valid;
  assign bus.c0_last_o         = w_c0_valid & w_at_last;
  assign bus.c1_last_o         = w_c1_valid & w_at_last;
  assign bus.c0_buffer_ready_o = r_buf_rdy[0];
  assign bus.c1_buffer_ready_o = r_buf_rdy[1];
  assign bus.grant_o           = {(r_state == S_GRANT) & r_grant,
                                  (r_state == S_GRANT) & ~r_grant};
  assign bus.busy_o            = (r_state != S_IDLE);
  assign bus.drop_count_o      = r_drop_cnt;
  assign bus.overrun_o         = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ram_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_read_arbiter
// Brief    : Self-checking bench for ram_read_arbiter with a burst scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_read_arbiter;
  localparam int DATA_W    = 36;
  localparam int BUF_DEPTH = 256;

  typedef struct {
    int port;
    int start;
    int beats;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_read_arbiter_if #(.DATA_W(DATA_W)) bus ();

  ram_read_arbiter #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int ram_word = 0;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  int                ord_q[$];
  int                bufrdy_cyc[$];
  int                last_cyc[$];
  int                pulse_at[$];

  int         n_beats[2];
  int         n_last[2];
  int         last_idx[2];
  int         n_bufrdy[2];
  int         n_ramhs, n_busy, n_cross, n_mirror_bad, n_grant_bad;
  logic [1:0] grant_or;
  bit         toggle_c1  = 1'b0;
  int         wd_beat    = 0;
  int         stop_beats = 0;

  function automatic logic [DATA_W-1:0] word_of(input int n);
    word_of = {4'hC ^ 4'(n), 32'(n)};
  endfunction

  task automatic expect_burst(input int port, input int start, input int beats);
    exp_t e;
    e.port = port; e.start = start; e.beats = beats;
    exp_q.push_back(e);
  endtask

  // RAM model: advances its word on every accepted beat.
  task automatic step();
    bit hs;
    hs = bus.ram_read_valid_i && bus.ram_read_ready_o;
    @(posedge clk);
    #1;
    if (hs) ram_word++;
    bus.ram_read_data_i    = word_of(ram_word);
    bus.ram_buffer_ready_i = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.req_i = 2'b00; bus.c0_ready_i = 1'b1; bus.c1_ready_i = 1'b1;
    bus.ram_buffer_ready_i = 1'b0; bus.ram_read_valid_i = 1'b1;
    bus.ram_read_data_i = word_of(ram_word);
    toggle_c1 = 1'b0; wd_beat = 0; stop_beats = 0;
    exp_q.delete();
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  task automatic run(input int max_cyc, input bit stop_idle, output bit timed_out);
    bit seen_busy;
    n_beats = '{0, 0}; n_last = '{0, 0}; last_idx = '{0, 0}; n_bufrdy = '{0, 0};
    n_ramhs = 0; n_busy = 0; n_cross = 0; n_mirror_bad = 0; n_grant_bad = 0;
    grant_or = 2'b00;
    q0.delete(); q1.delete(); ord_q.delete(); bufrdy_cyc.delete(); last_cyc.delete();
    seen_busy = 1'b0;
    timed_out = stop_idle || (stop_beats > 0);
    for (int c = 0; c < max_cyc; c++) begin
      if (toggle_c1) bus.c1_ready_i = (c % 2 == 0);
      foreach (pulse_at[k]) if (pulse_at[k] == c) bus.ram_buffer_ready_i = 1'b1;
      if (wd_beat > 0 && n_beats[0] >= wd_beat - 1) bus.req_i[0] = 1'b0;
      #1;
      if (bus.c0_valid_o && bus.c0_ready_i) begin
        n_beats[0]++; q0.push_back(bus.c0_data_o);
        if (bus.c0_last_o) begin n_last[0]++; last_idx[0] = n_beats[0]; last_cyc.push_back(c); end
      end
      if (bus.c1_valid_o && bus.c1_ready_i) begin
        n_beats[1]++; q1.push_back(bus.c1_data_o);
        if (bus.c1_last_o) begin n_last[1]++; last_idx[1] = n_beats[1]; last_cyc.push_back(c); end
      end
      if (bus.c0_buffer_ready_o) begin n_bufrdy[0]++; ord_q.push_back(0); bufrdy_cyc.push_back(c); end
      if (bus.c1_buffer_ready_o) begin n_bufrdy[1]++; ord_q.push_back(1); bufrdy_cyc.push_back(c); end
      if (bus.ram_read_valid_i && bus.ram_read_ready_o) n_ramhs++;
      if (bus.busy_o) begin n_busy++; seen_busy = 1'b1; end
      grant_or = grant_or | bus.grant_o;
      if (bus.grant_o == 2'b11) n_grant_bad++;
      if ((bus.c0_valid_o && !bus.grant_o[0]) || (bus.c1_valid_o && !bus.grant_o[1])) n_cross++;
      if ((bus.grant_o == 2'b10 && bus.ram_read_ready_o != bus.c1_ready_i) ||
          (bus.grant_o == 2'b01 && bus.ram_read_ready_o != bus.c0_ready_i)) n_mirror_bad++;
      if (stop_idle && seen_busy && !bus.busy_o) begin timed_out = 1'b0; break; end
      if (stop_beats > 0 && n_beats[0] == stop_beats) begin timed_out = 1'b0; break; end
      step();
    end
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    rst = 1'b1;
    bus.req_i = 2'b11; bus.c0_ready_i = 1'b1; bus.c1_ready_i = 1'b1;
    bus.ram_read_valid_i = 1'b1; bus.ram_buffer_ready_i = 1'b1;
    bus.ram_read_data_i = word_of(ram_word);
    step(); step();
    #1;
    outs = {bus.ram_read_ready_o, bus.c0_valid_o, bus.c1_valid_o, bus.c0_buffer_ready_o,
            bus.c1_buffer_ready_o, bus.c0_last_o, bus.c1_last_o, bus.grant_o, bus.busy_o};
    checks++;
    if (outs !== 10'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=0", outs); end
    checks++;
    if (bus.drop_count_o !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", bus.drop_count_o); end
    checks++;
    if (bus.overrun_o !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun_o); end
    rst = 1'b0;
  endtask

  task automatic test_single_grant();
    bit to; int base; int nbad; exp_t e; logic [DATA_W-1:0] got_w; int first_br;
    reset_dut();
    base = ram_word;
    bus.req_i = 2'b01; bus.c1_ready_i = 1'b0;
    pulse_at = '{0};
    expect_burst(0, base, BUF_DEPTH);
    run(400, 1'b1, to);
    checks++; if (to) begin failures++; $display("FAIL single_timeout got=busy exp=idle"); end
    checks++;
    if (n_bufrdy[0] != 1 || n_bufrdy[1] != 0) begin
      failures++; $display("FAIL single_bufrdy got=%0d/%0d exp=1/0", n_bufrdy[0], n_bufrdy[1]);
    end
    first_br = (bufrdy_cyc.size() > 0) ? bufrdy_cyc[0] : -1;
    checks++; if (first_br != 1) begin failures++; $display("FAIL single_bufrdy_cycle got=%0d exp=1", first_br); end
    checks++; if (n_beats[0] != BUF_DEPTH) begin failures++; $display("FAIL single_beats got=%0d exp=%0d", n_beats[0], BUF_DEPTH); end
    checks++;
    if (n_last[0] != 1 || last_idx[0] != BUF_DEPTH) begin
      failures++; $display("FAIL single_last got=%0d@%0d exp=1@%0d", n_last[0], last_idx[0], BUF_DEPTH);
    end
    checks++; if (grant_or !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", grant_or); end
    checks++;
    if (n_beats[1] != 0 || n_cross != 0) begin
      failures++; $display("FAIL single_c1_valid got=%0d/%0d exp=0/0", n_beats[1], n_cross);
    end
    checks++; if (n_busy != BUF_DEPTH) begin failures++; $display("FAIL single_busy_len got=%0d exp=%0d", n_busy, BUF_DEPTH); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nbad = 0;
      for (int i = 0; i < e.beats; i++) begin
        if (e.port == 0 && q0.size() > 0)      got_w = q0.pop_front();
        else if (e.port == 1 && q1.size() > 0) got_w = q1.pop_front();
        else                                   got_w = '0;
        if (got_w !== word_of(e.start + i)) nbad++;
      end
      checks++;
      if (nbad != 0) begin failures++; $display("FAIL single_data port=%0d bad_beats=%0d exp=0", e.port, nbad); end
    end
  endtask

  task automatic test_round_robin();
    bit to; int base; int nbad; exp_t e; logic [DATA_W-1:0] got_w;
    int m_last; int w; int exp_ord; int got_ord;
    reset_dut();
    base = ram_word;
    bus.req_i = 2'b11;
    pulse_at = '{0, 300, 600};
    m_last = 1; exp_ord = 0;
    for (int k = 0; k < 3; k++) begin
      w = 1 - m_last;
      exp_ord = exp_ord * 10 + w;
      expect_burst(w, base + k * BUF_DEPTH, BUF_DEPTH);
      m_last = w;
    end
    run(900, 1'b0, to);
    got_ord = (ord_q.size() == 3) ? ord_q[0] * 100 + ord_q[1] * 10 + ord_q[2] : -1;
    checks++; if (got_ord != exp_ord) begin failures++; $display("FAIL rr_order got=%0d exp=%0d", got_ord, exp_ord); end
    checks++;
    if (n_beats[0] != 2 * BUF_DEPTH || n_beats[1] != BUF_DEPTH) begin
      failures++; $display("FAIL rr_beats got=%0d/%0d exp=%0d/%0d", n_beats[0], n_beats[1], 2 * BUF_DEPTH, BUF_DEPTH);
    end
    checks++;
    if (n_last[0] != 2 || n_last[1] != 1) begin
      failures++; $display("FAIL rr_last got=%0d/%0d exp=2/1", n_last[0], n_last[1]);
    end
    checks++; if (bus.drop_count_o !== 16'd0) begin failures++; $display("FAIL rr_drop got=%0d exp=0", bus.drop_count_o); end
    checks++; if (n_grant_bad != 0) begin failures++; $display("FAIL rr_onehot got=%0d exp=0", n_grant_bad); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nbad = 0;
      for (int i = 0; i < e.beats; i++) begin
        if (e.port == 0 && q0.size() > 0)      got_w = q0.pop_front();
        else if (e.port == 1 && q1.size() > 0) got_w = q1.pop_front();
        else                                   got_w = '0;
        if (got_w !== word_of(e.start + i)) nbad++;
      end
      checks++;
      if (nbad != 0) begin failures++; $display("FAIL rr_data port=%0d bad_beats=%0d exp=0", e.port, nbad); end
    end
  endtask

  task automatic test_no_requester();
    bit to;
    reset_dut();
    bus.req_i = 2'b00;
    pulse_at = '{0};
    run(400, 1'b1, to);
    checks++; if (to) begin failures++; $display("FAIL drain_timeout got=busy exp=idle"); end
    checks++; if (n_ramhs != BUF_DEPTH) begin failures++; $display("FAIL drain_beats got=%0d exp=%0d", n_ramhs, BUF_DEPTH); end
    checks++; if (n_busy != BUF_DEPTH) begin failures++; $display("FAIL drain_ready_len got=%0d exp=%0d", n_busy, BUF_DEPTH); end
    checks++;
    if (n_beats[0] + n_beats[1] + n_bufrdy[0] + n_bufrdy[1] != 0 || grant_or !== 2'b00) begin
      failures++; $display("FAIL drain_consumer_activity got=%0d grant=%b exp=0 00",
                           n_beats[0] + n_beats[1] + n_bufrdy[0] + n_bufrdy[1], grant_or);
    end
    checks++; if (bus.drop_count_o !== 16'd1) begin failures++; $display("FAIL drain_drop got=%0d exp=1", bus.drop_count_o); end
  endtask

  task automatic test_backpressure();
    bit to; int base; int nbad; exp_t e; logic [DATA_W-1:0] got_w;
    reset_dut();
    base = ram_word;
    bus.req_i = 2'b10; bus.c0_ready_i = 1'b0; toggle_c1 = 1'b1;
    pulse_at = '{0};
    expect_burst(1, base, BUF_DEPTH);
    run(700, 1'b1, to);
    toggle_c1 = 1'b0;
    checks++; if (to) begin failures++; $display("FAIL bp_timeout got=busy exp=idle"); end
    checks++; if (n_beats[1] != BUF_DEPTH || n_beats[0] != 0) begin failures++; $display("FAIL bp_beats got=%0d/%0d exp=0/%0d", n_beats[0], n_beats[1], BUF_DEPTH); end
    checks++;
    if (n_last[1] != 1 || last_idx[1] != BUF_DEPTH) begin
      failures++; $display("FAIL bp_last got=%0d@%0d exp=1@%0d", n_last[1], last_idx[1], BUF_DEPTH);
    end
    checks++; if (n_mirror_bad != 0) begin failures++; $display("FAIL bp_ready_mirror got=%0d exp=0", n_mirror_bad); end
    checks++; if (n_busy != 2 * BUF_DEPTH) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", n_busy, 2 * BUF_DEPTH); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nbad = 0;
      for (int i = 0; i < e.beats; i++) begin
        if (e.port == 0 && q0.size() > 0)      got_w = q0.pop_front();
        else if (e.port == 1 && q1.size() > 0) got_w = q1.pop_front();
        else                                   got_w = '0;
        if (got_w !== word_of(e.start + i)) nbad++;
      end
      checks++;
      if (nbad != 0) begin failures++; $display("FAIL bp_data port=%0d bad_beats=%0d exp=0", e.port, nbad); end
    end
  endtask

  task automatic test_pending_overrun();
    bit to; int gap;
    reset_dut();
    bus.req_i = 2'b01;
    pulse_at = '{0, 100};
    run(700, 1'b0, to);
    checks++; if (n_bufrdy[0] != 2) begin failures++; $display("FAIL pend_bursts got=%0d exp=2", n_bufrdy[0]); end
    gap = (bufrdy_cyc.size() > 1 && last_cyc.size() > 0) ? bufrdy_cyc[1] - last_cyc[0] : -1;
    checks++; if (gap != 2) begin failures++; $display("FAIL pend_gap got=%0d exp=2", gap); end
    checks++; if (bus.overrun_o !== 1'b0) begin failures++; $display("FAIL pend_overrun got=%b exp=0", bus.overrun_o); end

    reset_dut();
    bus.req_i = 2'b01;
    pulse_at = '{0, 100, 150};
    run(700, 1'b0, to);
    checks++; if (n_bufrdy[0] != 2) begin failures++; $display("FAIL ovr_bursts got=%0d exp=2", n_bufrdy[0]); end
    checks++; if (bus.overrun_o !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", bus.overrun_o); end
    bus.req_i = 2'b00;
    for (int i = 0; i < 20; i++) step();
    #1;
    checks++; if (bus.overrun_o !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", bus.overrun_o); end
    reset_dut();
    checks++; if (bus.overrun_o !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", bus.overrun_o); end
  endtask

  task automatic test_withdraw();
    bit to; int base; int nbad; exp_t e; logic [DATA_W-1:0] got_w; int first;
    reset_dut();
    base = ram_word;
    bus.req_i = 2'b01; wd_beat = 100;
    pulse_at = '{0};
    expect_burst(0, base, 100);
    run(400, 1'b1, to);
    wd_beat = 0;
    checks++; if (to) begin failures++; $display("FAIL wd_timeout got=busy exp=idle"); end
    checks++; if (n_beats[0] != 100) begin failures++; $display("FAIL wd_beats got=%0d exp=100", n_beats[0]); end
    checks++; if (n_last[0] != 0) begin failures++; $display("FAIL wd_last got=%0d exp=0", n_last[0]); end
    checks++; if (n_ramhs != BUF_DEPTH) begin failures++; $display("FAIL wd_total got=%0d exp=%0d", n_ramhs, BUF_DEPTH); end
    checks++; if (bus.drop_count_o !== 16'd0) begin failures++; $display("FAIL wd_drop got=%0d exp=0", bus.drop_count_o); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); nbad = 0;
      for (int i = 0; i < e.beats; i++) begin
        if (e.port == 0 && q0.size() > 0)      got_w = q0.pop_front();
        else if (e.port == 1 && q1.size() > 0) got_w = q1.pop_front();
        else                                   got_w = '0;
        if (got_w !== word_of(e.start + i)) nbad++;
      end
      checks++;
      if (nbad != 0) begin failures++; $display("FAIL wd_data port=%0d bad_beats=%0d exp=0", e.port, nbad); end
    end
    // A withdrawn burst does not count as served, so the next tie still goes to port 0.
    bus.req_i = 2'b11;
    pulse_at = '{0};
    run(400, 1'b1, to);
    first = (ord_q.size() > 0) ? ord_q[0] : -1;
    checks++; if (first != 0) begin failures++; $display("FAIL wd_next_tie got=%0d exp=0", first); end
  endtask

  task automatic test_reset_mid_burst();
    bit to; logic [9:0] outs; logic [3:0] post;
    reset_dut();
    bus.req_i = 2'b01; stop_beats = 50;
    pulse_at = '{0};
    run(400, 1'b0, to);
    stop_beats = 0;
    checks++; if (to) begin failures++; $display("FAIL rstmid_reach got=%0d exp=50", n_beats[0]); end
    rst = 1'b1;
    step();
    #1;
    outs = {bus.ram_read_ready_o, bus.c0_valid_o, bus.c1_valid_o, bus.c0_buffer_ready_o,
            bus.c1_buffer_ready_o, bus.c0_last_o, bus.c1_last_o, bus.grant_o, bus.busy_o};
    checks++; if (outs !== 10'b0) begin failures++; $display("FAIL rstmid_outputs got=%b exp=0", outs); end
    checks++; if (n_last[0] != 0) begin failures++; $display("FAIL rstmid_last got=%0d exp=0", n_last[0]); end
    rst = 1'b0;
    bus.req_i = 2'b11;
    bus.ram_buffer_ready_i = 1'b1;
    #1;
    step();
    #1;
    post = {bus.c1_buffer_ready_o, bus.c0_buffer_ready_o, bus.grant_o};
    checks++; if (post !== 4'b0101) begin failures++; $display("FAIL rstmid_tie got=%b exp=0101", post); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.req_i = 2'b00; bus.c0_ready_i = 1'b0; bus.c1_ready_i = 1'b0;
    bus.ram_read_valid_i = 1'b0; bus.ram_buffer_ready_i = 1'b0;
    bus.ram_read_data_i = word_of(0);
    test_reset();
    test_single_grant();
    test_round_robin();
    test_no_requester();
    test_backpressure();
    test_pending_overrun();
    test_withdraw();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_read_arbiter.md
Name: ram_read_arbiter

Overview:
- Shares the ping-pong RAM read port (ram_logic read side) between two consumers, e.g. vu_meter_6led on port 0 and a future streamer/beamformer on port 1.
- Grants whole buffers: each buffer_ready event goes as one locked BUF_DEPTH-beat burst to one requester, chosen round-robin.
- With no requester, the buffer is drained and counted as dropped, so ping-pong swapping never stalls.

Parameters:
DATA_W, 36, width of RAM read data
BUF_DEPTH, 256, beats per buffer (power of two)
CNT_W, $clog2(BUF_DEPTH), beat counter width (derived)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
ram_read_data_i  in  DATA_W  RAM read data
ram_read_valid_i  in  1  RAM read data valid
ram_read_ready_o  out  1  read ready to RAM
ram_buffer_ready_i  in  1  1-cycle pulse: full buffer ready
req_i  in  2  per-consumer level request for buffers
c0_data_o / c1_data_o  out  DATA_W  ram_read_data_i broadcast (combinational)
c0_valid_o / c1_valid_o  out  1  beat valid to consumer
c0_ready_i / c1_ready_i  in  1  consumer ready
c0_buffer_ready_o / c1_buffer_ready_o  out  1  1-cycle pulse at start of granted burst
c0_last_o / c1_last_o  out  1  final beat of burst (qualified by valid)
grant_o  out  2  one-hot current grant, 00 when idle or draining
busy_o  out  1  state != IDLE
drop_count_o  out  16  buffers drained with no requester, saturating
overrun_o  out  1  sticky: buffer_ready arrived while one already pending

Behaviour:
- Reset (sync, rst_i=1): state=IDLE, beat_cnt=0, pending_q=0, last_served=1 (port 0 wins first tie). All outputs 0 the next cycle: ram_read_ready_o, cN_valid_o, cN_buffer_ready_o, cN_last_o, grant_o, busy_o, drop_count_o, overrun_o.
- Pending capture:
  - avail = ram_buffer_ready_i | pending_q.
  - pending_q is set by a pulse not consumed this cycle and cleared when IDLE leaves.
  - A pulse while pending_q=1 and not consumed sets overrun_o; the pending event is kept, the extra one is lost.
- FSM states IDLE, GRANT, DRAIN:
  - IDLE, avail=0: stay.
  - IDLE, avail=1, req_i!=0 -> GRANT next cycle. Winner: sole requester, or on a tie the port != last_served. grant_q latched; cN_buffer_ready_o pulses for exactly 1 cycle, registered, coincident with the first GRANT cycle.
  - IDLE, avail=1, req_i==0 -> DRAIN; drop_count_o increments (saturates at 0xFFFF).
  - GRANT: ram_read_ready_o = cN_ready_i of the granted port. cN_valid_o = ram_read_valid_i for the granted port; the other port's valid is 0.
  - GRANT, beat: a beat is ram_read_valid_i & ram_read_ready_o and increments beat_cnt.
  - GRANT, last beat: cN_last_o = valid & (beat_cnt==BUF_DEPTH-1). On that beat -> IDLE, beat_cnt=0, last_served=granted port.
  - GRANT, request withdrawn (req_i[granted] deasserts) -> DRAIN next cycle. beat_cnt is kept; the remaining beats are discarded; no cN_last_o; drop_count_o unchanged.
  - DRAIN: ram_read_ready_o=1, both valids 0. On the beat with beat_cnt==BUF_DEPTH-1 -> IDLE, beat_cnt=0; last_served unchanged.
- Latency:
  - Data/valid/ready routing is combinational, zero added latency.
  - First beat is accepted no earlier than the cycle after the IDLE decision.
  - Minimum burst is BUF_DEPTH cycles plus 1 idle cycle between bursts.
- Simultaneous events:
  - A buffer pulse on the final beat sets pending_q; IDLE then grants on the next cycle.
  - A req_i change in IDLE is sampled in the decision cycle only.
- req_i changes on the non-granted port during a burst have no effect.
- grant_o is one-hot only in GRANT. busy_o=1 in GRANT and DRAIN.
- Reset mid-burst aborts immediately with no last pulse. The RAM side is re-synchronised by ram_logic's own reset.

Test Plan:
- Port-0 grant: req_i=01, c0_ready_i=1, one buffer pulse, RAM valid continuous -> c0_buffer_ready_o pulses once; 256 beats on c0; c0_last_o on beat 256 only; grant_o=01 throughout; c1_valid_o=0; busy_o falls after the last beat.
- Round-robin: req_i=11, three buffer pulses spaced 300 cycles apart -> grants go c0, c1, c0; each burst is 256 beats; drop_count_o=0.
- No requester: req_i=00, one pulse -> DRAIN; ram_read_ready_o=1; 256 beats discarded; drop_count_o=1; no cN_valid_o or buffer_ready pulses.
- Backpressure: c1 granted, c1_ready_i toggles 1/0 each cycle -> ram_read_ready_o mirrors it; burst takes ~512 cycles; beat_cnt advances only on handshakes; c1_last_o on handshake 256.
- Pending/overrun: one pulse mid-burst -> next burst starts 1 cycle after the last beat, overrun_o=0. Two pulses mid-burst -> overrun_o=1 and sticky until reset.
- Withdraw/reset:
  - c0 drops req at beat 100 -> 156 beats drained, no c0_last_o, drop_count_o unchanged.
  - rst_i=1 at beat 50 -> all outputs 0 next cycle; first post-reset tie grants port 0.
